// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - shared constants, state encoding and divider helper for the OV7670 SCCB sequencer
package sccb_pkg;

  localparam logic [7:0]  SCCB_WRITE_ID = 8'h42;
  localparam logic [15:0] MARK_END      = 16'hFFFF;
  localparam logic [15:0] MARK_DELAY    = 16'hFFF0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_BIT,
    S_STOP,
    S_GAP,
    S_DELAY,
    S_DONE
  } sccb_state_t;

  // Quarter-bit divider, floored, never below one clk cycle.
  function automatic int sccb_div(input int clk_hz, input int sccb_hz);
    int d;
    d = clk_hz / (4 * sccb_hz);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/sccb_cfg_rom.sv
// rtl/sccb_cfg_rom.sv - synchronous register table for OV7670 QQVGA/RGB565 bring-up
module sccb_cfg_rom
  import sccb_pkg::*;
#(
  parameter int          ROM_AW    = 6,
  parameter bit          ALT_EN    = 1'b0,
  parameter logic [63:0] ALT_TABLE = {4{16'hFFFF}}
) (
  input  logic              clk,
  input  logic [ROM_AW-1:0] addr,
  output logic [15:0]       data
);

  logic [15:0] rom_word;

  // ALT_EN swaps in a four-entry table; unused slots read as the end marker.
  always_comb begin
    rom_word = MARK_END;
    if (ALT_EN) begin
      if (32'(addr) < 32'd4) rom_word = ALT_TABLE[{addr[1:0], 4'b0000} +: 16];
    end else begin
      case (addr)
        ROM_AW'(0):  rom_word = 16'h1280;
        ROM_AW'(1):  rom_word = MARK_DELAY;
        ROM_AW'(2):  rom_word = 16'h1204;
        ROM_AW'(3):  rom_word = 16'h1101;
        ROM_AW'(4):  rom_word = 16'h0C04;
        ROM_AW'(5):  rom_word = 16'h3E1A;
        ROM_AW'(6):  rom_word = 16'h703A;
        ROM_AW'(7):  rom_word = 16'h7135;
        ROM_AW'(8):  rom_word = 16'h7222;
        ROM_AW'(9):  rom_word = 16'h73F2;
        ROM_AW'(10): rom_word = 16'hA202;
        ROM_AW'(11): rom_word = 16'h40D0;
        ROM_AW'(12): rom_word = 16'h8C00;
        ROM_AW'(13): rom_word = 16'h1500;
        ROM_AW'(14): rom_word = 16'h3A04;
        ROM_AW'(15): rom_word = 16'h1716;
        ROM_AW'(16): rom_word = 16'h1804;
        ROM_AW'(17): rom_word = 16'h3224;
        ROM_AW'(18): rom_word = 16'h1902;
        ROM_AW'(19): rom_word = 16'h1A7A;
        ROM_AW'(20): rom_word = 16'h030A;
        default:     rom_word = MARK_END;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    data <= rom_word;
  end

endmodule

// File: rtl/ov7670_sccb_config.sv
// rtl/ov7670_sccb_config.sv - walks the register table and writes each entry to the OV7670 over 3-phase SCCB
module ov7670_sccb_config
  import sccb_pkg::*;
#(
  parameter int          CLK_HZ       = 25000000,
  parameter int          SCCB_HZ      = 100000,
  parameter int          ROM_AW       = 6,
  parameter int          DELAY_CYCLES = 25000,
  parameter bit          ALT_EN       = 1'b0,
  parameter logic [63:0] ALT_TABLE    = {4{16'hFFFF}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              sioc,
  output logic              siod_o,
  output logic              siod_oe,
  output logic              busy,
  output logic              done,
  output logic [ROM_AW-1:0] reg_idx
);

  localparam int DIV = sccb_div(CLK_HZ, SCCB_HZ);
  localparam int TW  = $clog2(DIV + 1);
  localparam int DW  = $clog2(DELAY_CYCLES + 1);
  localparam logic [ROM_AW-1:0] LAST_IDX = '1;

  sccb_state_t       state;
  logic [TW-1:0]     tick_cnt;
  logic              tick;
  logic [1:0]        q;
  logic [1:0]        phase;
  logic [3:0]        pos;
  logic [1:0]        nxt_phase;
  logic [3:0]        nxt_pos;
  logic              last_pos;
  logic [DW-1:0]     delay_cnt;
  logic [ROM_AW-1:0] rom_addr;
  logic [15:0]       rom_data;

  assign tick      = (tick_cnt == TW'(DIV - 1));
  assign last_pos  = (pos == 4'd8);
  assign nxt_pos   = last_pos ? 4'd0 : pos + 4'd1;
  assign nxt_phase = last_pos ? phase + 2'd1 : phase;

  // Present the next index one cycle early so LOAD sees its entry after a single cycle.
  always_comb begin
    rom_addr = reg_idx;
    if (state == S_IDLE || state == S_DONE) rom_addr = '0;
    else if (state == S_GAP || state == S_DELAY) rom_addr = reg_idx + 1'b1;
  end

  sccb_cfg_rom #(
    .ROM_AW   (ROM_AW),
    .ALT_EN   (ALT_EN),
    .ALT_TABLE(ALT_TABLE)
  ) u_rom (
    .clk (clk),
    .addr(rom_addr),
    .data(rom_data)
  );

  // {oe, o} for one bit slot; slot 8 of each phase releases the line.
  function automatic logic [1:0] bit_drive(input logic [1:0] ph, input logic [3:0] p,
                                           input logic [15:0] e);
    logic [7:0] b;
    b = (ph == 2'd0) ? SCCB_WRITE_ID : (ph == 2'd1) ? e[15:8] : e[7:0];
    if (p == 4'd8) return 2'b00;
    return {1'b1, b[3'd7 - p[2:0]]};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      sioc      <= 1'b1;
      siod_o    <= 1'b0;
      siod_oe   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      reg_idx   <= '0;
      tick_cnt  <= '0;
      q         <= '0;
      phase     <= '0;
      pos       <= '0;
      delay_cnt <= '0;
    end else begin
      if (state inside {S_LOAD, S_START, S_BIT, S_STOP, S_GAP})
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_LOAD;
            busy    <= 1'b1;
            done    <= 1'b0;
            reg_idx <= '0;
          end
        end

        S_LOAD: begin
          case (rom_data)
            MARK_END: state <= S_DONE;
            MARK_DELAY: begin
              state     <= S_DELAY;
              delay_cnt <= '0;
            end
            default: begin
              state    <= S_START;
              tick_cnt <= '0;
              q        <= '0;
              sioc     <= 1'b1;
              siod_oe  <= 1'b1;
              siod_o   <= 1'b1;
            end
          endcase
        end

        S_START: begin
          if (tick) begin
            if (q == 2'd0) begin
              siod_o <= 1'b0;
              q      <= 2'd1;
            end else begin
              state              <= S_BIT;
              tick_cnt           <= '0;
              q                  <= '0;
              phase              <= '0;
              pos                <= '0;
              sioc               <= 1'b0;
              {siod_oe, siod_o}  <= bit_drive(2'd0, 4'd0, rom_data);
            end
          end
        end

        S_BIT: begin
          if (tick) begin
            q <= q + 2'd1;
            case (q)
              2'd0:    sioc <= 1'b1;
              2'd1:    sioc <= 1'b1;
              2'd2:    sioc <= 1'b0;
              default: begin
                if (phase == 2'd2 && last_pos) begin
                  state   <= S_STOP;
                  sioc    <= 1'b1;
                  siod_oe <= 1'b1;
                  siod_o  <= 1'b0;
                end else begin
                  phase             <= nxt_phase;
                  pos               <= nxt_pos;
                  {siod_oe, siod_o} <= bit_drive(nxt_phase, nxt_pos, rom_data);
                end
              end
            endcase
          end
        end

        S_STOP: begin
          if (tick) begin
            if (q == 2'd0) begin
              siod_o <= 1'b1;
              q      <= 2'd1;
            end else begin
              state   <= S_GAP;
              siod_oe <= 1'b0;
              q       <= '0;
            end
          end
        end

        S_GAP: begin
          if (tick) begin
            q <= q + 2'd1;
            if (q == 2'd3) begin
              if (reg_idx == LAST_IDX) state <= S_DONE;
              else begin
                reg_idx <= reg_idx + 1'b1;
                state   <= S_LOAD;
              end
            end
          end
        end

        S_DELAY: begin
          if (delay_cnt == DW'(DELAY_CYCLES - 1)) begin
            if (reg_idx == LAST_IDX) state <= S_DONE;
            else begin
              reg_idx <= reg_idx + 1'b1;
              state   <= S_LOAD;
            end
          end else begin
            delay_cnt <= delay_cnt + 1'b1;
          end
        end

        S_DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (start && !busy) begin
            state   <= S_LOAD;
            busy    <= 1'b1;
            done    <= 1'b0;
            reg_idx <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// tb/tb_ov7670_sccb_config.sv - table-driven bench: three DUTs with small tables, SCCB bus decoder and checks
module tb_ov7670_sccb_config;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start   [3];
  logic       sioc    [3];
  logic       siod_o  [3];
  logic       siod_oe [3];
  logic       busy    [3];
  logic       done    [3];
  logic [5:0] reg_idx [3];

  int tests = 0;
  int fails = 0;

  ov7670_sccb_config #(.CLK_HZ(400), .SCCB_HZ(100), .ROM_AW(6), .DELAY_CYCLES(50), .ALT_EN(1'b1),
    .ALT_TABLE({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h1280})) dut_a (
    .clk(clk), .rst(rst), .start(start[0]), .sioc(sioc[0]), .siod_o(siod_o[0]),
    .siod_oe(siod_oe[0]), .busy(busy[0]), .done(done[0]), .reg_idx(reg_idx[0]));

  ov7670_sccb_config #(.CLK_HZ(400), .SCCB_HZ(100), .ROM_AW(6), .DELAY_CYCLES(50), .ALT_EN(1'b1),
    .ALT_TABLE({16'hFFFF, 16'h1101, 16'hFFF0, 16'h1280})) dut_b (
    .clk(clk), .rst(rst), .start(start[1]), .sioc(sioc[1]), .siod_o(siod_o[1]),
    .siod_oe(siod_oe[1]), .busy(busy[1]), .done(done[1]), .reg_idx(reg_idx[1]));

  ov7670_sccb_config #(.CLK_HZ(400), .SCCB_HZ(100), .ROM_AW(6), .DELAY_CYCLES(50), .ALT_EN(1'b1),
    .ALT_TABLE({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF})) dut_c (
    .clk(clk), .rst(rst), .start(start[2]), .sioc(sioc[2]), .siod_o(siod_o[2]),
    .siod_oe(siod_oe[2]), .busy(busy[2]), .done(done[2]), .reg_idx(reg_idx[2]));

  // Bus decoder: start/stop conditions, data sampled on SIOC rising edges.
  typedef struct {
    logic [7:0]  id;
    logic [7:0]  rg;
    logic [7:0]  vl;
    logic [26:0] oe_bits;
    int          nb;
    int          gap;
  } tx_t;

  tx_t         tx_log[$];
  int          nbits    [3];
  bit          in_frame [3];
  logic [26:0] dbits    [3];
  logic [26:0] obits    [3];
  logic        p_s      [3];
  logic        p_o      [3];
  logic        p_oe     [3];
  int          falls    [3];
  int          idle_run [3];
  int          last_run [3];
  int          gap_cur  [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      nbits[i] = 0; in_frame[i] = 0; falls[i] = 0; idle_run[i] = 0; last_run[i] = 0;
      gap_cur[i] = 0; p_s[i] = 1'b1; p_o[i] = 1'b0; p_oe[i] = 1'b0;
      dbits[i] = '0; obits[i] = '0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (p_s[i] === 1'b1 && sioc[i] === 1'b0) falls[i] <= falls[i] + 1;
      if (sioc[i] === 1'b1 && siod_oe[i] === 1'b0) idle_run[i] <= idle_run[i] + 1;
      else begin
        idle_run[i] <= 0;
        if (idle_run[i] > 0) last_run[i] <= idle_run[i];
      end
      if (!rst) begin
        in_frame[i] <= 1'b0;
      end else if (sioc[i] === 1'b1 && p_s[i] === 1'b1 && siod_oe[i] === 1'b1 && p_oe[i] === 1'b1) begin
        if (p_o[i] === 1'b1 && siod_o[i] === 1'b0) begin
          in_frame[i] <= 1'b1;
          nbits[i]    <= 0;
          gap_cur[i]  <= last_run[i];
        end else if (p_o[i] === 1'b0 && siod_o[i] === 1'b1 && in_frame[i]) begin
          tx_log.push_back('{dbits[i][26:19], dbits[i][17:10], dbits[i][8:1], obits[i],
                             nbits[i], gap_cur[i]});
          in_frame[i] <= 1'b0;
        end
      end
      if (rst && in_frame[i] && sioc[i] === 1'b1 && p_s[i] === 1'b0 && nbits[i] < 27) begin
        dbits[i][26 - nbits[i]] <= siod_o[i];
        obits[i][26 - nbits[i]] <= siod_oe[i];
        nbits[i]                <= nbits[i] + 1;
      end
      p_s[i]  <= sioc[i];
      p_o[i]  <= siod_o[i];
      p_oe[i] <= siod_oe[i];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         dut;
    bit         mid_start;
    int         exp_busy;
    int         exp_ntx;
    int         exp_falls;
    logic [7:0] rg0, vl0, rg1, vl1;
    int         exp_gap1;
  } vec_t;

  vec_t vecs[6];
  localparam logic [26:0] OE_MASK = 27'b111111110_111111110_111111110;

  task automatic do_run(input int v);
    int d, cyc, base, fbase;
    logic was_done;
    bit inj;
    d        = vecs[v].dut;
    base     = tx_log.size();
    fbase    = falls[d];
    was_done = done[d];
    inj      = 0;
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    check($sformatf("v%0d busy_rise", v), busy[d], 1);
    if (was_done === 1'b1) begin
      check($sformatf("v%0d done_drop", v), done[d], 0);
      check($sformatf("v%0d idx_restart", v), reg_idx[d], 0);
    end
    cyc = 0;
    while (busy[d] === 1'b1 && cyc < 5000) begin
      cyc++;
      @(negedge clk);
      start[d] = vecs[v].mid_start && !inj && in_frame[d] && nbits[d] == 5;
      if (start[d]) inj = 1;
    end
    start[d] = 1'b0;
    check($sformatf("v%0d busy_len", v), cyc, vecs[v].exp_busy);
    check($sformatf("v%0d done", v), done[d], 1);
    check($sformatf("v%0d sioc_idle", v), sioc[d], 1);
    check($sformatf("v%0d ntx", v), tx_log.size() - base, vecs[v].exp_ntx);
    check($sformatf("v%0d falls", v), falls[d] - fbase, vecs[v].exp_falls);
    for (int k = 0; k < vecs[v].exp_ntx && base + k < tx_log.size(); k++) begin
      check($sformatf("v%0d tx%0d id", v, k), tx_log[base+k].id, 8'h42);
      check($sformatf("v%0d tx%0d reg", v, k), tx_log[base+k].rg, (k == 0) ? vecs[v].rg0 : vecs[v].rg1);
      check($sformatf("v%0d tx%0d val", v, k), tx_log[base+k].vl, (k == 0) ? vecs[v].vl0 : vecs[v].vl1);
      check($sformatf("v%0d tx%0d oe_bits", v, k), tx_log[base+k].oe_bits, OE_MASK);
      check($sformatf("v%0d tx%0d nbits", v, k), tx_log[base+k].nb, 27);
      if (k == 1) check($sformatf("v%0d tx1 idle_gap", v), tx_log[base+k].gap, vecs[v].exp_gap1);
    end
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{0, 1'b0, 119, 1, 28, 8'h12, 8'h80, 8'h00, 8'h00, 0};
    vecs[1] = '{0, 1'b1, 119, 1, 28, 8'h12, 8'h80, 8'h00, 8'h00, 0};
    vecs[2] = '{1, 1'b0, 287, 2, 56, 8'h12, 8'h80, 8'h11, 8'h01, 56};
    vecs[3] = '{2, 1'b0, 2,   0, 0,  8'h00, 8'h00, 8'h00, 8'h00, 0};
    vecs[4] = '{1, 1'b0, 287, 2, 56, 8'h12, 8'h80, 8'h11, 8'h01, 56};
    vecs[5] = '{0, 1'b0, 119, 1, 28, 8'h12, 8'h80, 8'h00, 8'h00, 0};

    rst = 1'b0;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) start[i] = 1'($urandom_range(0, 1));
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("rst%0d d%0d sioc", k, i), sioc[i], 1);
        check($sformatf("rst%0d d%0d oe", k, i), siod_oe[i], 0);
        check($sformatf("rst%0d d%0d busy", k, i), busy[i], 0);
        check($sformatf("rst%0d d%0d done", k, i), done[i], 0);
        check($sformatf("rst%0d d%0d idx", k, i), reg_idx[i], 0);
      end
    end
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 5; v++) do_run(v);

    // Reset in the second data bit of the register byte, then replay from entry 0.
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    cyc = 0;
    while (!(in_frame[0] && nbits[0] == 11) && cyc < 1000) begin
      cyc++;
      @(negedge clk);
    end
    check("midrst reached", cyc < 1000, 1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst sioc", sioc[0], 1);
    check("midrst oe", siod_oe[0], 0);
    check("midrst busy", busy[0], 0);
    check("midrst done", done[0], 0);
    check("midrst idx", reg_idx[0], 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    do_run(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
